// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: RAW stalls,
// EX-resolved branch/call flushes and return sequencing, plus stall statistics.
module pipe_hazard_ctrl #(
  parameter logic [3:0]  OP_RET      = 4'b1111,
  parameter int unsigned RET_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [3:0]       id_rs,
  input  logic [3:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             idex_reg_write,
  input  logic [3:0]       idex_rd,
  input  logic             exmem_reg_write,
  input  logic [3:0]       exmem_rd,
  input  logic             ex_pc_src,
  input  logic             wb_ret,
  output logic             pc_hold,
  output logic [1:0]       pc_sel,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             ret_err
);

  localparam int unsigned WCNT_W = (RET_TIMEOUT > 1) ? $clog2(RET_TIMEOUT) : 1;
  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_EX  = 2'd1;
  localparam logic [1:0] PC_RET = 2'd2;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(RET_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    S_RUN,
    S_RET_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              ret_err_q, ret_err_d;

  logic       pc_hold_c;
  logic [1:0] pc_sel_c;
  logic       ifid_hold_c;
  logic       ifid_flush_c;
  logic       idex_bubble_c;

  logic rs_match, rt_match, data_haz, ret_in_id;

  // RAW check against EX and MEM only; WB writes before the register file read
  assign rs_match = id_rs_used && (id_rs != 4'd0) &&
                    ((idex_reg_write && (idex_rd == id_rs)) ||
                     (exmem_reg_write && (exmem_rd == id_rs)));
  assign rt_match = id_rt_used && (id_rt != 4'd0) &&
                    ((idex_reg_write && (idex_rd == id_rt)) ||
                     (exmem_reg_write && (exmem_rd == id_rt)));
  assign data_haz  = id_valid && (rs_match || rt_match);
  assign ret_in_id = id_valid && (id_opcode == OP_RET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      ret_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      ret_err_q   <= ret_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    ret_err_d     = ret_err_q;
    pc_hold_c     = 1'b0;
    pc_sel_c      = PC_SEQ;
    ifid_hold_c   = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (ex_pc_src) begin
          // Wrong-path hazards and returns in ID are discarded by the flush
          pc_sel_c      = PC_EX;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (data_haz) begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (ret_in_id) begin
          state_d = S_RET_WAIT;
          wcnt_d  = '0;
        end
      end
      S_RET_WAIT: begin
        // Kill whatever was fetched behind the return until its target is known
        pc_hold_c     = 1'b1;
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        if (wb_ret) begin
          pc_sel_c  = PC_RET;
          pc_hold_c = 1'b0;
          state_d   = S_RUN;
          wcnt_d    = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          ret_err_d = 1'b1;
          state_d   = S_RUN;
          wcnt_d    = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Saturating count of PC-hold cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_hold_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign pc_hold     = rst_n & pc_hold_c;
  assign pc_sel      = rst_n ? pc_sel_c : PC_SEQ;
  assign ifid_hold   = rst_n & ifid_hold_c;
  assign ifid_flush  = rst_n & ifid_flush_c;
  assign idex_bubble = rst_n & idex_bubble_c;
  assign stall_cnt   = stall_cnt_q;
  assign ret_err     = ret_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; a second instance with a 4-bit
// stall counter shares the stimulus to exercise saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs_used, id_rt_used;
  logic [3:0] id_opcode, id_rs, id_rt, idex_rd, exmem_rd;
  logic       idex_reg_write, exmem_reg_write, ex_pc_src, wb_ret;

  logic        pc_hold, ifid_hold, ifid_flush, idex_bubble, ret_err;
  logic [1:0]  pc_sel;
  logic [15:0] stall_cnt;
  logic        pc_hold4, ifid_hold4, ifid_flush4, idex_bubble4, ret_err4;
  logic [1:0]  pc_sel4;
  logic [3:0]  stall_cnt4;

  typedef struct packed {
    logic        hold;
    logic [1:0]  sel;
    logic        ihold;
    logic        iflush;
    logic        bub;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [15:0] exp_cnt  = '0;
  logic [3:0]  exp_cnt4 = '0;
  logic        exp_err  = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .idex_reg_write(idex_reg_write), .idex_rd(idex_rd),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .ex_pc_src(ex_pc_src), .wb_ret(wb_ret),
    .pc_hold(pc_hold), .pc_sel(pc_sel), .ifid_hold(ifid_hold),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stall_cnt(stall_cnt), .ret_err(ret_err)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .idex_reg_write(idex_reg_write), .idex_rd(idex_rd),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .ex_pc_src(ex_pc_src), .wb_ret(wb_ret),
    .pc_hold(pc_hold4), .pc_sel(pc_sel4), .ifid_hold(ifid_hold4),
    .ifid_flush(ifid_flush4), .idex_bubble(idex_bubble4),
    .stall_cnt(stall_cnt4), .ret_err(ret_err4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [3:0] rs,
                        input logic rsu, input logic [3:0] rt, input logic rtu,
                        input logic xw, input logic [3:0] xrd, input logic mw,
                        input logic [3:0] mrd, input logic br, input logic wr);
    id_valid = v; id_opcode = op; id_rs = rs; id_rs_used = rsu; id_rt = rt;
    id_rt_used = rtu; idex_reg_write = xw; idex_rd = xrd; exmem_reg_write = mw;
    exmem_rd = mrd; ex_pc_src = br; wb_ret = wr;
  endtask

  task automatic idle();
    set_in(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // Called just after a falling edge with inputs set: push expectation,
  // compare the settled outputs, then advance one rising edge.
  task automatic cyc(input string tag, input logic h, input logic [1:0] s,
                     input logic ih, input logic fl, input logic bb);
    exp_t e, o;
    e = '{hold: h, sel: s, ihold: ih, iflush: fl, bub: bb,
          cnt: exp_cnt, cnt4: exp_cnt4, err: exp_err};
    sb_q.push_back(e);
    #2;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_pc_hold"},     32'(pc_hold),     32'(e.hold));
      check({tag, "_pc_sel"},      32'(pc_sel),      32'(e.sel));
      check({tag, "_ifid_hold"},   32'(ifid_hold),   32'(e.ihold));
      check({tag, "_ifid_flush"},  32'(ifid_flush),  32'(e.iflush));
      check({tag, "_idex_bubble"}, 32'(idex_bubble), 32'(e.bub));
      check({tag, "_stall_cnt"},   32'(stall_cnt),   32'(e.cnt));
      check({tag, "_stall_cnt4"},  32'(stall_cnt4),  32'(e.cnt4));
      check({tag, "_ret_err"},     32'(ret_err),     32'(e.err));
      o = e;
    end
    @(posedge clk);
    if (!rst_n) begin
      exp_cnt = '0; exp_cnt4 = '0; exp_err = 1'b0;
    end else if (h) begin
      if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
      if (exp_cnt4 != 4'hf) exp_cnt4 = exp_cnt4 + 4'd1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    exp_cnt = '0; exp_cnt4 = '0; exp_err = 1'b0;
    cyc(tag, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic issue_ret(input string tag);
    set_in(1'b1, 4'hf, 4'h1, 1'b1, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    cyc(tag, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    do_reset("reset");
    cyc("idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // RAW on rs: EX in cycle 0, MEM in cycle 1, clear in cycle 2
    set_in(1'b1, 4'h0, 4'h3, 1'b1, 4'h0, 1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0);
    cyc("raw_ex", 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    set_in(1'b1, 4'h0, 4'h3, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h3, 1'b0, 1'b0);
    cyc("raw_mem", 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    set_in(1'b1, 4'h0, 4'h3, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h3, 1'b0, 1'b0);
    cyc("raw_clear", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("raw_stall_cnt_2", 32'(stall_cnt), 32'd2);

    // R0 destination and an unused rt never stall; a used rt does
    set_in(1'b1, 4'h0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b1, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0);
    cyc("r0_unused", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 4'h0, 4'h0, 1'b1, 4'h5, 1'b1, 1'b1, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0);
    cyc("rt_used", 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    set_in(1'b0, 4'h0, 4'h0, 1'b1, 4'h5, 1'b1, 1'b1, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0);
    cyc("invalid_id", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Branch flush beats a hazard and a return in ID; state stays RUN
    set_in(1'b1, 4'hf, 4'h3, 1'b1, 4'h0, 1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc("branch", 1'b0, 2'd1, 1'b0, 1'b1, 1'b1);
    idle();
    cyc("after_branch", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Nominal return; branch and hazard in RET_WAIT are ignored
    issue_ret("ret_t0");
    set_in(1'b1, 4'h0, 4'h3, 1'b1, 4'h0, 1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc("ret_t1", 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    idle();
    cyc("ret_t2", 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    wb_ret = 1'b1;
    cyc("ret_t3", 1'b0, 2'd2, 1'b0, 1'b1, 1'b1);
    idle();
    cyc("ret_t4", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("ret_stall_cnt_5", 32'(stall_cnt), 32'd5);

    // Return timeout after 8 RET_WAIT cycles
    issue_ret("tmo_issue");
    idle();
    for (int i = 0; i < 8; i++) cyc("tmo_wait", 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    exp_err = 1'b1;
    cyc("tmo_run", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    wb_ret = 1'b1;
    cyc("tmo_late_wb", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    idle();
    do_reset("tmo_reset");
    cyc("tmo_cleared", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Reset inside RET_WAIT abandons the return
    issue_ret("rst_issue");
    idle();
    cyc("rst_wait", 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    do_reset("rst_mid_ret");
    wb_ret = 1'b1;
    cyc("rst_abandoned", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // 20 held cycles saturate the 4-bit counter
    set_in(1'b1, 4'h0, 4'h7, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h7, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc("sat_hold", 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    idle();
    cyc("sat_done", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("sat_cnt4_15", 32'(stall_cnt4), 32'd15);
    check("sat_cnt16_20", 32'(stall_cnt), 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
